// File: rtl/quadruples_counter_pkg.sv
// Shared constants and the small-binomial helper for the quadruple counter.
// choose_small evaluates C(n,r) for r<=4 as a falling-factorial quotient.
package quadruples_counter_pkg;

    localparam int SIZE_DEFAULT    = 100;
    localparam int COUNT_W_DEFAULT = 16;
    localparam int QUAD            = 4;
    localparam int K_MAX           = 4;

    // n<=255 keeps n(n-1)(n-2)(n-3) below 2^32, so the product never wraps.
    function automatic logic [31:0] choose_small(input logic [7:0] n, input logic [7:0] r);
        logic [31:0] n32;
        logic [31:0] res;
        n32 = {24'd0, n};
        res = 32'd0;
        if (n < r) begin
            res = 32'd0;
        end else begin
            case (r)
                8'd0:    res = 32'd1;
                8'd1:    res = n32;
                8'd2:    res = (n32 * (n32 - 32'd1)) / 32'd2;
                8'd3:    res = (n32 * (n32 - 32'd1) * (n32 - 32'd2)) / 32'd6;
                8'd4:    res = (n32 * (n32 - 32'd1) * (n32 - 32'd2) * (n32 - 32'd3)) / 32'd24;
                default: res = 32'd0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/quadruples_counter_popcount.sv
// Combinational population count of a SIZE-bit vector (SIZE <= 255).
module qc_popcount
    import quadruples_counter_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic [SIZE-1:0] vec,
    output logic [7:0]      ones
);

    // Sum of all element bits; synthesis balances the chain into a tree.
    always_comb begin
        ones = 8'd0;
        for (int i = 0; i < SIZE; i++) begin
            ones = ones + {7'd0, vec[i]};
        end
    end

endmodule

// File: rtl/quadruples_counter.sv
// Four-stage pipeline counting index quadruples whose bit sum equals k,
// via C(P,k)*C(SIZE-P,4-k) with a saturating result.
module quadruples_counter
    import quadruples_counter_pkg::*;
#(
    parameter int SIZE    = SIZE_DEFAULT,
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [SIZE-1:0]    input_array,
    input  logic [7:0]         k,
    output logic               valid_out,
    output logic [COUNT_W-1:0] count
);

    localparam logic [7:0]  SIZE_B    = 8'(SIZE);
    localparam logic [63:0] COUNT_MAX = (64'd1 << COUNT_W) - 64'd1;

    logic [SIZE-1:0]    arr_d, arr_q;
    logic [7:0]         k1_d, k1_q, k2_d, k2_q;
    logic               v1_d, v1_q, v2_d, v2_q, v3_d, v3_q, vo_d, vo_q;
    logic [7:0]         p_d, p_q, q_d, q_q;
    logic [31:0]        a_d, a_q, b_d, b_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic [7:0]         pop_s;
    logic [63:0]        product_s;

    qc_popcount #(.SIZE(SIZE)) u_popcount (
        .vec  (arr_q),
        .ones (pop_s)
    );

    // Next-state for all stages; only the result register is gated by valid.
    always_comb begin
        arr_d     = input_array;
        k1_d      = k;
        v1_d      = valid_in;
        p_d       = pop_s;
        q_d       = SIZE_B - pop_s;
        k2_d      = k1_q;
        v2_d      = v1_q;
        a_d       = (k2_q > 8'(K_MAX)) ? 32'd0 : choose_small(p_q, k2_q);
        b_d       = choose_small(q_q, 8'(QUAD) - k2_q);
        v3_d      = v2_q;
        product_s = {32'd0, a_q} * {32'd0, b_q};
        vo_d      = v3_q;
        count_d   = count_q;
        if (v3_q) begin
            if (product_s > COUNT_MAX) begin
                count_d = '1;
            end else begin
                count_d = product_s[COUNT_W-1:0];
            end
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight work is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_q   <= '0;
            k1_q    <= 8'd0;
            v1_q    <= 1'b0;
            p_q     <= 8'd0;
            q_q     <= 8'd0;
            k2_q    <= 8'd0;
            v2_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            v3_q    <= 1'b0;
            vo_q    <= 1'b0;
            count_q <= '0;
        end else begin
            arr_q   <= arr_d;
            k1_q    <= k1_d;
            v1_q    <= v1_d;
            p_q     <= p_d;
            q_q     <= q_d;
            k2_q    <= k2_d;
            v2_q    <= v2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v3_q    <= v3_d;
            vo_q    <= vo_d;
            count_q <= count_d;
        end
    end

    assign valid_out = vo_q;
    assign count     = count_q;

endmodule

// File: tb/tb_quadruples_counter.sv
// Self-checking bench: directed table, stream/bubble/reset sequences and
// random vectors, all against a closed-form binomial reference model.
module tb_quadruples_counter;

    localparam int SIZE    = 100;
    localparam int COUNT_W = 16;

    logic               clk;
    logic               rst;
    logic               valid_in;
    logic [SIZE-1:0]    input_array;
    logic [7:0]         k;
    logic               valid_out;
    logic [COUNT_W-1:0] count;

    quadruples_counter #(.SIZE(SIZE), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .input_array (input_array),
        .k           (k),
        .valid_out   (valid_out),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] arr;
        logic [7:0]      kk;
        logic [15:0]     exp;
    } vec_t;

    typedef struct {
        bit          v;
        logic [15:0] c;
    } ent_t;

    int          n_checks;
    int          n_fail;
    ent_t        pipe[$];
    logic [15:0] exp_cnt;
    vec_t        tbl[7];

    function automatic longint unsigned binom(input int n, input int r);
        longint unsigned res;
        if (r > n) return 64'd0;
        res = 64'd1;
        for (int i = 0; i < r; i++) res = res * longint'(n - i) / longint'(i + 1);
        return res;
    endfunction

    function automatic logic [15:0] ref_count(input logic [SIZE-1:0] a, input logic [7:0] kk);
        int p;
        longint unsigned prod;
        p = $countones(a);
        if (kk > 8'd4) return 16'd0;
        prod = binom(p, int'(kk)) * binom(SIZE - p, 4 - int'(kk));
        return (prod > 64'd65535) ? 16'hFFFF : prod[15:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        ent_t e;
        e.v = 1'b0;
        e.c = 16'd0;
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(e);
        exp_cnt = 16'd0;
    endtask

    // One clock: apply inputs, advance, compare against the model's oldest entry.
    task automatic step(input bit v, input logic [SIZE-1:0] a, input logic [7:0] kk);
        ent_t e;
        valid_in    = v;
        input_array = a;
        k           = kk;
        e.v = v;
        e.c = v ? ref_count(a, kk) : 16'd0;
        pipe.push_back(e);
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        if (e.v) exp_cnt = e.c;
        chk("valid_out", 64'(valid_out), 64'(e.v));
        chk("count", 64'(count), 64'(exp_cnt));
    endtask

    logic [SIZE-1:0] all1, six, two, rv;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        all1 = '1;
        six  = 100'h3F;
        two  = (100'd1 << 10) | (100'd1 << 99);
        tbl[0] = '{all1, 8'd0,   16'd0};
        tbl[1] = '{all1, 8'd4,   16'd65535};
        tbl[2] = '{six,  8'd3,   16'd1880};
        tbl[3] = '{six,  8'd1,   16'd65535};
        tbl[4] = '{two,  8'd2,   16'd4753};
        tbl[5] = '{two,  8'd5,   16'd0};
        tbl[6] = '{two,  8'd200, 16'd0};

        rst = 1'b1;
        valid_in = 1'b0;
        input_array = '0;
        k = 8'd0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        rst = 1'b0;

        // Directed table: each vector isolated, result checked after 4 edges.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].arr, tbl[i].kk);
            for (int j = 0; j < 3; j++) step(1'b0, '0, 8'd0);
            chk($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'd1);
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp));
        end

        // Back-to-back stream, then a bubble, then drain.
        step(1'b1, all1, 8'd0);
        step(1'b1, six,  8'd3);
        step(1'b1, two,  8'd2);
        step(1'b1, all1, 8'd4);
        step(1'b0, '0,   8'd0);
        step(1'b1, six,  8'd3);
        for (int j = 0; j < 5; j++) step(1'b0, '0, 8'd0);
        chk("stream_last_count", 64'(count), 64'd1880);

        // Reset with three results in flight: outputs drop immediately.
        step(1'b1, all1, 8'd4);
        step(1'b1, six,  8'd3);
        step(1'b1, two,  8'd2);
        valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid_out", 64'(valid_out), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        for (int j = 0; j < 5; j++) step(1'b0, '0, 8'd0);
        step(1'b1, two, 8'd2);
        for (int j = 0; j < 3; j++) step(1'b0, '0, 8'd0);
        chk("postrst_count", 64'(count), 64'd4753);

        // Random vectors with varied density and occasional out-of-range k.
        for (int n = 0; n < 300; n++) begin
            int th;
            th = $urandom_range(0, 100);
            for (int b = 0; b < SIZE; b++) rv[b] = ($urandom_range(0, 99) < th);
            step(($urandom_range(0, 4) != 0), rv,
                 ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4)));
        end
        for (int j = 0; j < 4; j++) step(1'b0, '0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quadruples_counter.md
Name: quadruples_counter

Overview:
- Counts index quadruples i<j<l<m of a SIZE-bit input vector whose bit values sum to k, i.e. a[i]+a[j]+a[l]+a[m] == k.
- Uses the closed form C(P,k)·C(SIZE−P,4−k), where P is the popcount of the vector; it does not enumerate quadruples.
- Fully pipelined, one new vector per cycle, fixed latency, saturating 16-bit result.
- Sits as a statistics/accelerator leaf behind a valid-qualified data source.

Parameters:
- SIZE, 100, number of 1-bit elements in input_array (legal range 4..255).
- COUNT_W, 16, width of count; the result saturates at 2^COUNT_W−1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  input_array/k are valid this cycle.
- input_array  input  SIZE  element vector; bit n is element n.
- k  input  8  target sum (unsigned).
- valid_out  output  1  count is valid this cycle.
- count  output  COUNT_W  number of matching quadruples, saturated.

Behaviour:
- Reset: asynchronous on rst high. valid_out=0, count=0, all pipeline registers cleared. The first capture happens on the first clk rising edge after rst deasserts.
- Stage S1: register input_array, k and valid_in on every clk edge, with no stall or backpressure.
- Stage S2: P = popcount(S1 vector), 8 bits; Q = SIZE−P. Register P, Q, k and valid.
- Stage S3: compute A=C(P,k) and B=C(Q,4−k) for k in 0..4, using C(n,0)=1, C(n,1)=n, C(n,2)=n(n−1)/2, C(n,3)=n(n−1)(n−2)/6, C(n,4)=n(n−1)(n−2)(n−3)/24.
  - C(n,r)=0 when n<r; the falling-factorial product is naturally 0 in that case.
  - If k>4 (any value 5..255), force A=0.
  - A and B are 32-bit unsigned; register them with valid.
- Stage S4: product = A·B at 64-bit width. count = product > 2^COUNT_W−1 ? all-ones : product[COUNT_W−1:0]. Register count; valid_out = S3 valid.
- Latency: exactly 4 clk edges from the valid_in sample to valid_out/count. Throughput is 1 per cycle, and back-to-back inputs produce back-to-back outputs in order.
- When valid_out=0, count holds its last value. The count register loads only when S3 valid=1.
- Reset asserted mid-operation: all in-flight results are discarded and outputs return to 0 immediately (asynchronously).
- No X propagation from invalid slots: data registers may load freely, but valid gates the count update.

Decomposition:
- Package quadruples_counter_pkg holds:
  - constants SIZE_DEFAULT=100, COUNT_W_DEFAULT=16, QUAD=4, K_MAX=4;
  - function choose_small(n, r) returning a 32-bit C(n,r) for r≤4 (0 if r>4 or n<r).
- One sub-module, qc_popcount: a parameterised SIZE-bit popcount (adder tree, combinational), instantiated in S2.

Test Plan:
- All ones (SIZE=100), k=0, valid_in=1 -> after 4 cycles valid_out=1, count=0 (C(100,0)·C(0,4)=0).
- All ones, k=4 -> count=65535 (true value 3,921,225, saturated).
- Exactly 6 ones (bits 0..5 set), k=3 -> count=1880 (20·94). Same vector with k=1 -> 6·C(94,3)=6·134,044 → saturated 65535.
- Exactly 2 ones (bits 10, 99), k=2 -> count=4753 (1·C(98,2)). Same vector with k=5 and k=200 -> count=0.
- Back-to-back stream over four consecutive cycles, vectors {all ones k=0, 6 ones k=3, 2 ones k=2, all ones k=4} -> valid_out high for four consecutive cycles with counts 0, 1880, 4753, 65535 in order. Insert a valid_in=0 bubble -> a matching valid_out=0 gap with count held.
- Assert rst while 3 inputs are in flight -> valid_out=0 and count=0 immediately, and no stale result appears after release. The first post-reset input emerges exactly 4 cycles after it is sampled.
